// File: rtl/rs_sched_ctrl_pkg.sv
// Shared types for the reservation-station scheduler: FU classes and controller states.
package rs_sched_ctrl_pkg;

  localparam int unsigned NumFuClass = 4;

  // Encoding matches the line FUNC_UNIT field and the ex_stall bit order.
  typedef enum logic [1:0] {
    FuAlu  = 2'd0,
    FuMult = 2'd1,
    FuMem  = 2'd2,
    FuBr   = 2'd3
  } func_unit_e;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } rs_sched_state_e;

endpackage

// File: rtl/rs_sched_ctrl_if.sv
// Bundle between the scheduler, dispatch, the RS line array and the FU inputs.
interface rs_sched_ctrl_if #(
  parameter int unsigned RSLEN = 16,
  parameter int unsigned WAYS  = 3
);
  import rs_sched_ctrl_pkg::*;

  localparam int unsigned IDXW = $clog2(RSLEN);

  logic                            squash;
  logic [RSLEN-1:0]                line_busy;
  logic [RSLEN-1:0]                line_not_ready;
  logic [RSLEN-1:0][1:0]           line_func_unit;
  logic [WAYS-1:0]                 dp_valid;
  logic [NumFuClass-1:0]           ex_stall;

  logic [RSLEN-1:0]                line_enable;
  logic [RSLEN-1:0][1:0]           line_position;
  logic [RSLEN-1:0]                line_clear;
  logic                            dp_stall;
  logic [WAYS-1:0]                 issue_valid;
  logic [WAYS-1:0][IDXW-1:0]       issue_idx;

  // Environment side: drives line state and dispatch, consumes schedule decisions.
  modport master (
    output squash, line_busy, line_not_ready, line_func_unit, dp_valid, ex_stall,
    input  line_enable, line_position, line_clear, dp_stall, issue_valid, issue_idx
  );

  // Scheduler side.
  modport slave (
    input  squash, line_busy, line_not_ready, line_func_unit, dp_valid, ex_stall,
    output line_enable, line_position, line_clear, dp_stall, issue_valid, issue_idx
  );

endinterface

// File: rtl/rs_sched_ctrl_rr_picker.sv
// Rotating-priority selector: walks lines from start, wrapping, and fills up to WAYS slots
// with candidates whose FU class still has budget left this cycle.
module rs_sched_ctrl_rr_picker
  import rs_sched_ctrl_pkg::*;
#(
  parameter int unsigned RSLEN = 16,
  parameter int unsigned WAYS  = 3,
  localparam int unsigned IDXW = $clog2(RSLEN),
  localparam int unsigned CW   = $clog2(WAYS + 1)
) (
  input  logic [RSLEN-1:0]              cand,
  input  logic [RSLEN-1:0][1:0]         cls,
  input  logic [IDXW-1:0]               start,
  input  logic [NumFuClass-1:0][CW-1:0] limit,
  output logic [WAYS-1:0]               slot_valid,
  output logic [WAYS-1:0][IDXW-1:0]     slot_idx
);

  logic [NumFuClass-1:0][CW-1:0] used;
  logic [CW-1:0]                 filled;
  logic [IDXW-1:0]               idx;

  // Scan in rotated order; a class at its limit is skipped, not blocking later lines.
  always_comb begin
    used       = '0;
    filled     = '0;
    idx        = '0;
    slot_valid = '0;
    slot_idx   = '0;
    for (int i = 0; i < RSLEN; i++) begin
      idx = start + IDXW'(i);
      if (cand[idx] && (filled < CW'(WAYS)) && (used[cls[idx]] < limit[cls[idx]])) begin
        for (int s = 0; s < WAYS; s++) begin
          if (CW'(s) == filled) begin
            slot_valid[s] = 1'b1;
            slot_idx[s]   = idx;
          end
        end
        used[cls[idx]] = used[cls[idx]] + CW'(1);
        filled         = filled + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rs_sched_ctrl.sv
// Reservation-station controller: allocates free lines to dispatch ways, picks ready lines
// for issue with round-robin priority and FU-class limits, and clears issued/squashed lines.
module rs_sched_ctrl
  import rs_sched_ctrl_pkg::*;
#(
  parameter int unsigned RSLEN    = 16,
  parameter int unsigned WAYS     = 3,
  parameter int unsigned MULT_LAT = 4
) (
  input logic            clock,
  input logic            reset,
  rs_sched_ctrl_if.slave bus
);

  localparam int unsigned IDXW = $clog2(RSLEN);
  localparam int unsigned CW   = $clog2(WAYS + 1);
  localparam int unsigned MCW  = $clog2(MULT_LAT + 1);
  localparam int unsigned PW   = $clog2(RSLEN + 1);

  rs_sched_state_e fsm_q;
  logic [IDXW-1:0] rr_ptr_q;
  logic [MCW-1:0]  mult_cnt_q;

  logic                          run_ok;
  logic [RSLEN-1:0]              cand;
  logic [NumFuClass-1:0][CW-1:0] limit;
  logic [WAYS-1:0]               pick_valid;
  logic [WAYS-1:0][IDXW-1:0]     pick_idx;
  logic [RSLEN-1:0]              issue_clr;
  logic [IDXW-1:0]               last_idx;
  logic                          mult_issued;

  logic [RSLEN-1:0]              free;
  logic [PW-1:0]                 free_cnt;
  logic [PW-1:0]                 need_cnt;
  logic [PW-1:0]                 fill;
  logic [WAYS-1:0][PW-1:0]       rank;
  logic [RSLEN-1:0]              alloc_en;
  logic [RSLEN-1:0][1:0]         alloc_pos;
  logic                          alloc_ok;

  // Normal scheduling only happens in RUN with no squash and no reset.
  assign run_ok = !reset && (fsm_q == StRun) && !bus.squash;

  // Enables only ever target non-busy lines, so excluding line_enable from the candidate
  // set reduces to the busy term and keeps alloc and issue free of a combinational loop.
  assign cand = bus.line_busy & ~bus.line_not_ready & {RSLEN{run_ok}};

  // Per-class issue budget for this cycle; a stalled FU gets no budget at all.
  always_comb begin
    limit         = '0;
    limit[FuAlu]  = CW'(WAYS);
    limit[FuMult] = (mult_cnt_q == '0) ? CW'(1) : '0;
    limit[FuMem]  = CW'(1);
    limit[FuBr]   = CW'(1);
    for (int c = 0; c < NumFuClass; c++) begin
      if (bus.ex_stall[c]) limit[c] = '0;
    end
  end

  rs_sched_ctrl_rr_picker #(
    .RSLEN (RSLEN),
    .WAYS  (WAYS)
  ) u_picker (
    .cand       (cand),
    .cls        (bus.line_func_unit),
    .start      (rr_ptr_q),
    .limit      (limit),
    .slot_valid (pick_valid),
    .slot_idx   (pick_idx)
  );

  // Decode issued slots into line clears, the next rr start and multiplier occupancy.
  always_comb begin
    issue_clr   = '0;
    last_idx    = '0;
    mult_issued = 1'b0;
    for (int s = 0; s < WAYS; s++) begin
      if (pick_valid[s]) begin
        issue_clr[pick_idx[s]] = 1'b1;
        last_idx               = pick_idx[s];
        if (bus.line_func_unit[pick_idx[s]] == FuMult) mult_issued = 1'b1;
      end
    end
  end

  // Lowest-index-first allocation: the r-th valid way takes the r-th free line.
  always_comb begin
    free      = ~bus.line_busy & ~issue_clr;
    free_cnt  = '0;
    need_cnt  = '0;
    fill      = '0;
    rank      = '0;
    alloc_en  = '0;
    alloc_pos = '0;
    for (int i = 0; i < RSLEN; i++) begin
      free_cnt = free_cnt + PW'(free[i]);
    end
    for (int w = 0; w < WAYS; w++) begin
      rank[w]  = need_cnt;
      need_cnt = need_cnt + PW'(bus.dp_valid[w]);
    end
    for (int i = 0; i < RSLEN; i++) begin
      if (free[i]) begin
        for (int w = 0; w < WAYS; w++) begin
          if (bus.dp_valid[w] && (rank[w] == fill)) begin
            alloc_en[i]  = 1'b1;
            alloc_pos[i] = 2'(w);
          end
        end
        fill = fill + PW'(1);
      end
    end
  end

  // Dispatch is all-or-nothing.
  assign alloc_ok = run_ok && (free_cnt >= need_cnt);

  // Output gating by reset, squash and FSM state.
  always_comb begin
    bus.line_enable   = alloc_ok ? alloc_en : '0;
    bus.line_position = alloc_ok ? alloc_pos : '0;
    bus.dp_stall      = !alloc_ok;
    bus.issue_valid   = pick_valid;
    bus.issue_idx     = pick_idx;
    if (reset) begin
      bus.line_clear = '0;
    end else if (bus.squash) begin
      bus.line_clear = '1;
    end else begin
      bus.line_clear = issue_clr;
    end
  end

  // Controller state: RUN/FLUSH sequencing, round-robin pointer and multiplier busy counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q      <= StRun;
      rr_ptr_q   <= '0;
      mult_cnt_q <= '0;
    end else if (bus.squash) begin
      fsm_q      <= StFlush;
      rr_ptr_q   <= '0;
      mult_cnt_q <= '0;
    end else begin
      fsm_q <= StRun;
      if (|pick_valid) rr_ptr_q <= last_idx + IDXW'(1);
      if (mult_issued) begin
        mult_cnt_q <= MCW'(MULT_LAT);
      end else if (mult_cnt_q != '0) begin
        mult_cnt_q <= mult_cnt_q - MCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rs_sched_ctrl.sv
// Bench for rs_sched_ctrl: directed scenarios plus random traffic against a queue-based model.
module tb_rs_sched_ctrl;
  import rs_sched_ctrl_pkg::*;

  localparam int RSLEN    = 16;
  localparam int WAYS     = 3;
  localparam int MULT_LAT = 4;
  localparam int IW       = 4;

  logic clk = 1'b0;
  logic rst;

  rs_sched_ctrl_if #(.RSLEN(RSLEN), .WAYS(WAYS)) bus ();

  rs_sched_ctrl #(
    .RSLEN    (RSLEN),
    .WAYS     (WAYS),
    .MULT_LAT (MULT_LAT)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int m_rr;
  int m_mcnt;
  bit m_flush;

  // Model expectations for the current cycle
  logic [RSLEN-1:0]          e_en;
  logic [RSLEN-1:0]          e_clr;
  logic [RSLEN-1:0][1:0]     e_pos;
  logic                      e_stall;
  logic [WAYS-1:0]           e_iv;
  logic [WAYS-1:0][IW-1:0]   e_idx;
  int                        e_last;
  bit                        e_mult;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_eval();
    int lim[4];
    int used[4];
    int slots;
    int freeq[$];
    int need;
    int j;
    e_en = '0; e_clr = '0; e_pos = '0; e_iv = '0; e_idx = '0;
    e_stall = 1'b1; e_last = -1; e_mult = 1'b0;
    if (rst) return;
    if (bus.squash) begin
      e_clr = '1;
      return;
    end
    if (m_flush) return;
    lim = '{WAYS, (m_mcnt == 0) ? 1 : 0, 1, 1};
    for (int c = 0; c < 4; c++) begin
      if (bus.ex_stall[c]) lim[c] = 0;
      used[c] = 0;
    end
    slots = 0;
    for (int i = 0; i < RSLEN; i++) begin
      int l;
      int c;
      l = (m_rr + i) % RSLEN;
      c = int'(bus.line_func_unit[l]);
      if (slots < WAYS && bus.line_busy[l] && !bus.line_not_ready[l] && used[c] < lim[c]) begin
        e_iv[slots]  = 1'b1;
        e_idx[slots] = IW'(l);
        e_clr[l]     = 1'b1;
        used[c]++;
        slots++;
        e_last = l;
        if (c == 1) e_mult = 1'b1;
      end
    end
    for (int i = 0; i < RSLEN; i++) begin
      if (!bus.line_busy[i] && !e_clr[i]) freeq.push_back(i);
    end
    need = $countones(bus.dp_valid);
    if (freeq.size() < need) return;
    e_stall = 1'b0;
    j = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (bus.dp_valid[w]) begin
        e_en[freeq[j]]  = 1'b1;
        e_pos[freeq[j]] = 2'(w);
        j++;
      end
    end
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_rr = 0; m_flush = 1'b0; m_mcnt = 0;
    end else if (bus.squash) begin
      m_rr = 0; m_flush = 1'b1; m_mcnt = 0;
    end else begin
      m_flush = 1'b0;
      if (e_last >= 0) m_rr = (e_last + 1) % RSLEN;
      if (e_mult) m_mcnt = MULT_LAT;
      else if (m_mcnt > 0) m_mcnt--;
    end
  endfunction

  // Sample mid-cycle and compare every output against the model.
  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
    check_eq("line_enable", bus.line_enable, e_en);
    check_eq("line_clear", bus.line_clear, e_clr);
    check_eq("line_position", bus.line_position, e_pos);
    check_eq("dp_stall", bus.dp_stall, e_stall);
    check_eq("issue_valid", bus.issue_valid, e_iv);
    check_eq("issue_idx", bus.issue_idx, e_idx);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    bus.squash         = 1'b0;
    bus.line_busy      = '0;
    bus.line_not_ready = '1;
    bus.line_func_unit = '0;
    bus.dp_valid       = '0;
    bus.ex_stall       = '0;
  endtask

  initial begin
    m_rr = 0; m_mcnt = 0; m_flush = 1'b0;
    rst = 1'b1;
    set_idle();
    bus.dp_valid = 3'b111;

    // Reset state
    eval_cycle();
    check_eq("rst_stall", bus.dp_stall, 1'b1);
    check_eq("rst_en", bus.line_enable, 16'h0);
    next_cycle();

    // 1: all free, three ways
    rst = 1'b0;
    eval_cycle();
    check_eq("t1_en", bus.line_enable, 16'h0007);
    check_eq("t1_pos", bus.line_position, 32'h0000_0024);
    check_eq("t1_stall", bus.dp_stall, 1'b0);
    next_cycle();

    // 2: only lines 5 and 9 free
    bus.line_busy = 16'hFDDF;
    bus.dp_valid  = 3'b101;
    eval_cycle();
    check_eq("t2_en", bus.line_enable, 16'h0220);
    check_eq("t2_pos", bus.line_position, 32'h0008_0000);
    next_cycle();
    bus.dp_valid = 3'b111;
    eval_cycle();
    check_eq("t2_stall", bus.dp_stall, 1'b1);
    check_eq("t2_noen", bus.line_enable, 16'h0);
    next_cycle();

    // 3: walk rr_ptr to 14, then wrap-around issue
    set_idle();
    bus.line_busy      = 16'h2000;
    bus.line_not_ready = ~16'h2000;
    eval_cycle();
    check_eq("t3_pre_idx", bus.issue_idx, 12'h00D);
    next_cycle();
    bus.line_busy      = 16'hC018;
    bus.line_not_ready = ~16'hC018;
    eval_cycle();
    check_eq("t3_iv", bus.issue_valid, 3'b111);
    check_eq("t3_idx", bus.issue_idx, 12'h3FE);
    check_eq("t3_clr", bus.line_clear, 16'hC008);
    next_cycle();
    bus.line_busy      = 16'h0018;
    bus.line_not_ready = ~16'h0018;
    eval_cycle();
    check_eq("t3_rr4_idx", bus.issue_idx, 12'h034);
    next_cycle();

    // 4: multiplier occupancy
    bus.line_busy      = 16'h0006;
    bus.line_not_ready = ~16'h0006;
    bus.line_func_unit = 32'h0000_0014;
    eval_cycle();
    check_eq("t4_iv", bus.issue_valid, 3'b001);
    check_eq("t4_idx", bus.issue_idx, 12'h001);
    next_cycle();
    bus.line_busy      = 16'h0004;
    bus.line_not_ready = ~16'h0004;
    for (int k = 0; k < MULT_LAT; k++) begin
      eval_cycle();
      check_eq("t4_busy_iv", bus.issue_valid, 3'b000);
      next_cycle();
    end
    eval_cycle();
    check_eq("t4_late_iv", bus.issue_valid, 3'b001);
    check_eq("t4_late_idx", bus.issue_idx, 12'h002);
    next_cycle();
    bus.line_busy = '0;
    for (int k = 0; k < MULT_LAT; k++) begin
      eval_cycle();
      next_cycle();
    end
    bus.line_busy = 16'h0004;
    bus.ex_stall  = 4'b0010;
    eval_cycle();
    check_eq("t4_exst_iv", bus.issue_valid, 3'b000);
    next_cycle();
    bus.ex_stall = '0;
    eval_cycle();
    check_eq("t4_free_iv", bus.issue_valid, 3'b001);
    next_cycle();

    // 5: squash, flush, resume
    set_idle();
    bus.line_busy      = 16'h003F;
    bus.line_not_ready = ~16'h003F;
    bus.dp_valid       = 3'b111;
    bus.squash         = 1'b1;
    eval_cycle();
    check_eq("t5_clr", bus.line_clear, 16'hFFFF);
    check_eq("t5_stall", bus.dp_stall, 1'b1);
    check_eq("t5_iv", bus.issue_valid, 3'b000);
    next_cycle();
    bus.squash         = 1'b0;
    bus.line_busy      = '0;
    bus.line_not_ready = '1;
    eval_cycle();
    check_eq("t5_fl_stall", bus.dp_stall, 1'b1);
    check_eq("t5_fl_clr", bus.line_clear, 16'h0);
    next_cycle();
    eval_cycle();
    check_eq("t5_resume_en", bus.line_enable, 16'h0007);
    next_cycle();

    // 6: line freed by issue is not reused the same cycle
    bus.line_busy      = 16'h00FF;
    bus.line_not_ready = ~16'h0080;
    bus.dp_valid       = 3'b001;
    eval_cycle();
    check_eq("t6_clr", bus.line_clear, 16'h0080);
    check_eq("t6_en", bus.line_enable, 16'h0100);
    next_cycle();

    // Reset during FLUSH
    set_idle();
    bus.squash = 1'b1;
    eval_cycle();
    next_cycle();
    bus.squash = 1'b0;
    rst = 1'b1;
    eval_cycle();
    next_cycle();
    rst = 1'b0;
    bus.dp_valid = 3'b011;
    eval_cycle();
    check_eq("rst_fl_en", bus.line_enable, 16'h0003);
    next_cycle();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      rst                = ($urandom_range(0, 99) < 2);
      bus.squash         = ($urandom_range(0, 99) < 5);
      bus.line_busy      = ($urandom_range(0, 3) == 0) ? 16'($urandom | $urandom) : 16'($urandom);
      bus.line_not_ready = 16'($urandom & $urandom);
      bus.line_func_unit = 32'($urandom);
      bus.dp_valid       = 3'($urandom_range(0, 7));
      bus.ex_stall       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      eval_cycle();
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
